// File: rtl/aes_encrypt_iter_if.sv
// Handshake and data bundle for the iterative AES-128 encryptor.
// The master side is the host or testbench; the slave side is the cipher core.
interface aes_encrypt_iter_if;
   logic          in_valid;
   logic          in_ready;
   logic [127:0]  plaintext;
   logic [1407:0] keys;
   logic          out_valid;
   logic          out_ready;
   logic [127:0]  ciphertext;
   logic          busy;

   modport master (
      output in_valid,
      output plaintext,
      output keys,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  ciphertext,
      input  busy
   );

   modport slave (
      input  in_valid,
      input  plaintext,
      input  keys,
      input  out_ready,
      output in_ready,
      output out_valid,
      output ciphertext,
      output busy
   );
endinterface

// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryption: one full round per clock, ten rounds per block.
// The round-key schedule comes straight from the key expansion and is not
// registered here, so it must stay stable while a block is in flight.
module aes_encrypt_iter (
   input logic             clk,
   input logic             rst_n,
   aes_encrypt_iter_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StRound, StDone} st_e;

   st_e          st_q;
   logic [127:0] state_q;
   logic [3:0]   rnd_q;
   logic         in_ready_q;
   logic         out_valid_q;
   logic         busy_q;

   logic [127:0] round_key;
   logic [127:0] sub_w;
   logic [127:0] shift_w;
   logic [127:0] mix_w;
   logic [127:0] round_d;

   // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] acc;
      logic [7:0] aa;
      acc = 8'h00;
      aa  = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) acc = acc ^ aa;
         aa = xtime(aa);
      end
      return acc;
   endfunction

   // S-box from its definition: multiplicative inverse (x^254, which maps 0 to 0)
   // followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] sq;
      logic [7:0] inv;
      sq  = x;
      inv = 8'h01;
      for (int i = 1; i < 8; i++) begin
         sq  = gf_mul(sq, sq);
         inv = gf_mul(inv, sq);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] c);
      logic [7:0] a0, a1, a2, a3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
   endfunction

   // Select round key rnd from the flat schedule; out-of-range rounds give zero.
   always_comb begin
      round_key = '0;
      for (int r = 0; r < 11; r++) begin
         if (rnd_q == 4'(r)) round_key = bus.keys[1407 - 128 * r -: 128];
      end
   end

   // One cipher round on the state register; MixColumns is skipped in round 10.
   always_comb begin
      sub_w   = '0;
      shift_w = '0;
      mix_w   = '0;
      for (int i = 0; i < 16; i++) begin
         sub_w[127 - 8 * i -: 8] = sbox(state_q[127 - 8 * i -: 8]);
      end
      // Byte index is 4*col + row; row r rotates left by r columns.
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            shift_w[127 - 8 * (4 * c + r) -: 8] = sub_w[127 - 8 * (4 * ((c + r) % 4) + r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++) begin
         mix_w[127 - 32 * c -: 32] = mix_col(shift_w[127 - 32 * c -: 32]);
      end
      round_d = ((rnd_q == 4'd10) ? shift_w : mix_w) ^ round_key;
   end

   // Control FSM with registered handshake flags, plus the state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q        <= StIdle;
         state_q     <= '0;
         rnd_q       <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (st_q)
            StIdle: begin
               if (bus.in_valid && in_ready_q) begin
                  state_q    <= bus.plaintext ^ bus.keys[1407 -: 128];
                  rnd_q      <= 4'd1;
                  st_q       <= StRound;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            StRound: begin
               if (rnd_q == 4'd0 || rnd_q > 4'd10) begin
                  // Corrupted counter: abandon the block.
                  st_q        <= StIdle;
                  rnd_q       <= '0;
                  in_ready_q  <= 1'b1;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end else begin
                  state_q <= round_d;
                  if (rnd_q == 4'd10) begin
                     st_q        <= StDone;
                     out_valid_q <= 1'b1;
                  end else begin
                     rnd_q <= rnd_q + 4'd1;
                  end
               end
            end
            StDone: begin
               if (bus.out_ready) begin
                  st_q        <= StIdle;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               st_q        <= StIdle;
               rnd_q       <= '0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.busy       = busy_q;
   assign bus.ciphertext = state_q;

endmodule

// File: tb/tb_aes_encrypt_iter.sv
// Bench for aes_encrypt_iter: directed FIPS-197 vectors, backpressure, reset
// and randomized blocks checked through a scoreboard queue and an output monitor.
module tb_aes_encrypt_iter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_encrypt_iter_if bus ();

   aes_encrypt_iter dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0]   sbox_t [256];
   logic [127:0] exp_q [$];
   int           n_vec = 0;
   int           n_err = 0;
   int           cyc = 0;
   bit           rand_rdy = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // S-box via the log/antilog walk over generator 3.
   function automatic void build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b00};
         q = q ^ {q[3:0], 4'h0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endfunction

   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gm(input logic [7:0] a, input int k);
      // Only constants 1, 2, 3 are needed.
      if (k == 1) return a;
      if (k == 2) return xt(a);
      return xt(a) ^ a;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
   endfunction

   function automatic logic [1407:0] expand(input logic [127:0] key);
      logic [31:0]   w [44];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1407:0] ks;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i - 1];
         if (i % 4 == 0) begin
            t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = xt(rc);
         end
         w[i] = w[i - 4] ^ t;
      end
      ks = '0;
      for (int i = 0; i < 44; i++) ks[1407 - 32 * i -: 32] = w[i];
      return ks;
   endfunction

   // Reference cipher on a [row][col] byte matrix.
   function automatic logic [127:0] model(input logic [127:0] pt, input logic [1407:0] ks);
      logic [7:0]   st [4][4];
      logic [7:0]   tmp [4][4];
      logic [7:0]   a [4];
      logic [127:0] res;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            st[r][c] = pt[127 - 8 * (4 * c + r) -: 8] ^ ks[1407 - 8 * (4 * c + r) -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) tmp[r][c] = sbox_t[st[r][(c + r) % 4]];
         for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = tmp[r][c];
            if (rd < 10) begin
               st[0][c] = gm(a[0], 2) ^ gm(a[1], 3) ^ a[2] ^ a[3];
               st[1][c] = a[0] ^ gm(a[1], 2) ^ gm(a[2], 3) ^ a[3];
               st[2][c] = a[0] ^ a[1] ^ gm(a[2], 2) ^ gm(a[3], 3);
               st[3][c] = gm(a[0], 3) ^ a[1] ^ a[2] ^ gm(a[3], 2);
            end else begin
               for (int r = 0; r < 4; r++) st[r][c] = a[r];
            end
            for (int r = 0; r < 4; r++)
               st[r][c] = st[r][c] ^ ks[1407 - 128 * rd - 8 * (4 * c + r) -: 8];
         end
      end
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) res[127 - 8 * (4 * c + r) -: 8] = st[r][c];
      return res;
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: compare every completed output handshake against the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got %h expected none", bus.ciphertext);
            end else begin
               check("ciphertext", bus.ciphertext, exp_q.pop_front());
            end
         end
      end
   end

   // Random backpressure driver for the randomized phase.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rand_rdy) bus.out_ready = 1'($urandom_range(0, 1));
      end
   end

   // Offer a block, wait for acceptance, and record the accept cycle.
   task automatic send(input logic [127:0] pt, input logic [1407:0] ks, input logic [127:0] exp,
                       input bit push, input bit hold, output int acc);
      int t;
      t = 0;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && t < 300) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (!bus.in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: got in_ready=0 expected 1");
         bus.in_valid = 1'b0;
         acc = -1;
         return;
      end
      bus.plaintext = pt;
      bus.keys      = ks;
      @(posedge clk);
      #1;
      acc = cyc;
      if (!hold) bus.in_valid = 1'b0;
      if (push) exp_q.push_back(exp);
      check("busy_after_accept", bus.busy, 1);
      check("in_ready_after_accept", bus.in_ready, 0);
   endtask

   task automatic wait_out(output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 60) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   initial begin
      logic [127:0]  key1, pt1, ct1, key_b, pt_b, ct_b, ct_z;
      logic [1407:0] ks1, ks_b, ks_z, ks_r;
      logic [127:0]  key_r, pt_r;
      int            acc, acc2, lat, t;

      build_sbox();
      key1  = 128'h000102030405060708090a0b0c0d0e0f;
      pt1   = 128'h00112233445566778899aabbccddeeff;
      ct1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      key_b = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      pt_b  = 128'h3243f6a8885a308d313198a2e0370734;
      ct_b  = 128'h3925841d02dc09fbdc118597196a0b32;
      ct_z  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
      ks1   = expand(key1);
      ks_b  = expand(key_b);
      ks_z  = expand(128'h0);

      bus.in_valid  = 1'b0;
      bus.plaintext = '0;
      bus.keys      = '0;
      bus.out_ready = 1'b1;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", bus.in_ready, 1);
      check("reset_out_valid", bus.out_valid, 0);
      check("reset_busy", bus.busy, 0);
      check("reset_ciphertext", bus.ciphertext, 128'h0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // FIPS-197 C.1 with latency
      send(pt1, ks1, ct1, 1'b1, 1'b0, acc);
      wait_out(lat);
      check("latency_c1", lat, 10);
      repeat (3) @(posedge clk);
      #1;

      // Appendix B with round-1 state
      send(pt_b, ks_b, ct_b, 1'b1, 1'b0, acc);
      @(posedge clk);
      #1;
      check("round1_state", bus.ciphertext, 128'ha49c7ff2689f352b6b5bea43026a5049);
      wait_out(lat);
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: hold output 20 cycles, ignored in_valid pulse
      bus.out_ready = 1'b0;
      send(pt1, ks1, ct1, 1'b1, 1'b0, acc);
      wait_out(lat);
      check("bp_latency", lat, 10);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         if (i == 5) begin
            bus.plaintext = pt_b;
            bus.in_valid  = 1'b1;
         end
         if (i == 6) bus.in_valid = 1'b0;
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_ciphertext", bus.ciphertext, ct1);
         check("bp_in_ready", bus.in_ready, 0);
      end
      bus.plaintext = pt1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("bp_release_out_valid", bus.out_valid, 0);
      check("bp_release_in_ready", bus.in_ready, 1);
      check("bp_release_busy", bus.busy, 0);
      repeat (15) @(posedge clk);
      #1;
      check("bp_no_ghost_block", bus.busy, 0);

      // Back-to-back with in_valid and out_ready held high
      send(pt1, ks1, ct1, 1'b1, 1'b1, acc);
      send(pt_b, ks_b, ct_b, 1'b1, 1'b0, acc2);
      check("b2b_accept_spacing", acc2 - acc, 12);
      wait_out(lat);
      repeat (3) @(posedge clk);
      #1;

      // Reset during round 5
      send(pt1, ks1, ct1, 1'b0, 1'b0, acc);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_out_valid", bus.out_valid, 0);
      check("midrst_busy", bus.busy, 0);
      check("midrst_ciphertext", bus.ciphertext, 128'h0);
      check("midrst_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(pt1, ks1, ct1, 1'b1, 1'b0, acc);
      wait_out(lat);
      check("latency_after_reset", lat, 10);
      repeat (3) @(posedge clk);
      #1;

      // All-zero key and plaintext
      send(128'h0, ks_z, ct_z, 1'b1, 1'b0, acc);
      wait_out(lat);
      repeat (3) @(posedge clk);
      #1;

      // Randomized blocks against the reference model, random backpressure
      rand_rdy = 1'b1;
      for (int n = 0; n < 24; n++) begin
         key_r = {$urandom, $urandom, $urandom, $urandom};
         pt_r  = {$urandom, $urandom, $urandom, $urandom};
         ks_r  = expand(key_r);
         repeat ($urandom_range(0, 3)) @(posedge clk);
         #1;
         send(pt_r, ks_r, model(pt_r, ks_r), 1'b1, 1'b0, acc);
      end
      rand_rdy = 1'b0;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;

      // Drain the scoreboard
      t = 0;
      while (exp_q.size() > 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      check("scoreboard_drained", 128'(exp_q.size()), 0);
      repeat (2) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
